// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: sequencing controller for a small 8x8 SRAM macro.
// Accepts one read or write at a time and steps the array through
// precharge, word-line pulse, optional sense and a one-cycle response.
// All outputs are flops loaded from the next-state decode, so they are
// a clean Moore function of the registered state.
//
// Optional build macro: RAM_PRECHARGE_STRETCH_EN
//   defined   -> precharge phase lasts 2 cycles (all latencies +1)
//   undefined -> precharge phase lasts 1 cycle
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready for a request, bitlines held in precharge
// S_PRE   | request latched, bitlines still precharging, address shown
// S_WL    | decoder enabled, word line pulsed for WL_CYCLES cycles
// S_SENSE | read only: sense amps enabled, data captured on exit
// S_RESP  | one-cycle completion pulse on rsp_valid

module ram_access_ctrl #(
    parameter int WL_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic [2:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic [2:0] dec_a,
    output logic       dec_en,
    output logic       wwl_en,
    output logic       rwl_en,
    output logic       pre_n,
    output logic       sae,
    output logic [7:0] wbl,
    input  logic [7:0] sa_out
);

    // Out-of-range pulse widths are clamped rather than rejected.
    localparam int W_EFF = (WL_CYCLES < 1) ? 1 : ((WL_CYCLES > 4) ? 4 : WL_CYCLES);

`ifdef RAM_PRECHARGE_STRETCH_EN
    localparam int PRE_CYCLES = 2;
`else
    localparam int PRE_CYCLES = 1;
`endif

    // Phase timer is a down-counter; it is loaded with (length - 1) on
    // phase entry and the phase ends when it reaches zero.
    localparam logic [1:0] PRE_LOAD = 2'(PRE_CYCLES - 1);
    localparam logic [1:0] WL_LOAD  = 2'(W_EFF - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_WL    = 3'd2,
        S_SENSE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [2:0] addr_q, addr_d;
    logic       we_q, we_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;

    logic       req_ready_q, req_ready_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [2:0] dec_a_q, dec_a_d;
    logic       dec_en_q, dec_en_d;
    logic       wwl_en_q, wwl_en_d;
    logic       rwl_en_q, rwl_en_d;
    logic       pre_n_q, pre_n_d;
    logic       sae_q, sae_d;
    logic [7:0] wbl_q, wbl_d;

    // Next state, phase timer, request latch and read-data capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = S_PRE;
                    cnt_d   = PRE_LOAD;
                    addr_d  = req_addr;
                    we_d    = req_we;
                    wdata_d = req_wdata;
                end
            end
            S_PRE: begin
                if (cnt_q == 2'd0) begin
                    state_d = S_WL;
                    cnt_d   = WL_LOAD;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_WL: begin
                if (cnt_q == 2'd0) begin
                    state_d = we_q ? S_RESP : S_SENSE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_SENSE: begin
                state_d = S_RESP;
                rdata_d = sa_out;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output values for the upcoming state, registered alongside it.
    always_comb begin
        req_ready_d = (state_d == S_IDLE);
        pre_n_d     = !((state_d == S_IDLE) || (state_d == S_PRE));
        dec_en_d    = (state_d == S_WL);
        wwl_en_d    = dec_en_d && we_d;
        rwl_en_d    = dec_en_d && !we_d;
        dec_a_d     = (state_d == S_IDLE) ? 3'd0 : addr_d;
        wbl_d       = (dec_en_d && we_d) ? wdata_d : 8'd0;
        sae_d       = (state_d == S_SENSE);
        rsp_valid_d = (state_d == S_RESP);
    end

    // FSM state, datapath latches and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            addr_q      <= 3'd0;
            we_q        <= 1'b0;
            wdata_q     <= 8'd0;
            rdata_q     <= 8'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            dec_a_q     <= 3'd0;
            dec_en_q    <= 1'b0;
            wwl_en_q    <= 1'b0;
            rwl_en_q    <= 1'b0;
            pre_n_q     <= 1'b0;
            sae_q       <= 1'b0;
            wbl_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            dec_a_q     <= dec_a_d;
            dec_en_q    <= dec_en_d;
            wwl_en_q    <= wwl_en_d;
            rwl_en_q    <= rwl_en_d;
            pre_n_q     <= pre_n_d;
            sae_q       <= sae_d;
            wbl_q       <= wbl_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign dec_a     = dec_a_q;
    assign dec_en    = dec_en_q;
    assign wwl_en    = wwl_en_q;
    assign rwl_en    = rwl_en_q;
    assign pre_n     = pre_n_q;
    assign sae       = sae_q;
    assign wbl       = wbl_q;

endmodule
